counter_binary_mod: RTL
=======================

COUNTER_BINARY_MOD -- requirements
Module: counter_binary_mod

Interface
REQ-001 Parameter WIDTH, default 4, counter and data width in bits, legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0, d_out value after rst, must be <= 2^WIDTH-1.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  count enable; clear, preset and limit_we are not gated by en.
REQ-006 clear  in  1  synchronous clear of d_out to 0.
REQ-007 preset  in  1  synchronous load of d_in into d_out.
REQ-008 up_down  in  1  1 = count up, 0 = count down.
REQ-009 d_in  in  WIDTH  preset value.
REQ-010 limit_we  in  1  write strobe for the modulus limit register.
REQ-011 limit_in  in  WIDTH  new limit value, the highest count value.
REQ-012 sat_mode  in  1  1 = saturate at bounds, 0 = wrap; present only with COUNTER_SAT_EN.
REQ-013 ovf_clr  in  1  clears ovf_sticky.
REQ-014 d_out  out  WIDTH  current count.
REQ-015 tc  out  1  terminal count, combinational: (up_down && d_out==limit) || (!up_down && d_out==0).
REQ-016 wrap  out  1  registered one-cycle pulse on a wrap or saturation event.
REQ-017 ovf_sticky  out  1  registered sticky flag for wrap or saturation events.

Function
REQ-018 The count range SHALL be 0..limit inclusive; limit is an internal WIDTH-bit register.
REQ-019 Per clk edge, priority SHALL be: clear, then preset, then count (en=1), else hold.
REQ-020 A preset with d_in > effective limit SHALL load the effective limit (clamp).
REQ-021 An up count at d_out==limit SHALL load 0; a down count at d_out==0 SHALL load limit; each such event SHALL pulse wrap high for exactly the following cycle.
REQ-022 An up count below limit SHALL add 1 and a down count above 0 SHALL subtract 1, modulo 2^WIDTH, with no wrap pulse.
REQ-023 With limit_we=1, limit SHALL take limit_in at that edge; the effective limit for that same edge's preset clamp and bound checks SHALL be limit_in.
REQ-024 If limit_we=1, no clear or preset is active, and the resulting d_out would exceed limit_in, d_out SHALL become limit_in; wrap SHALL NOT pulse.
REQ-025 With limit=0 and en=1, d_out SHALL stay 0 and wrap SHALL be high every cycle.
REQ-026 ovf_sticky SHALL set on any cycle in which wrap is set, and clear on ovf_clr; a simultaneous set and clear SHALL leave it set.
REQ-027 clear or preset SHALL suppress the wrap pulse for that edge.

Reset
REQ-028 rst SHALL immediately force d_out=RESET_VAL, limit=2^WIDTH-1, wrap=0, ovf_sticky=0, independent of clk.
REQ-029 Deassertion of rst SHALL take effect synchronously; the first count occurs on the first clk edge with rst low.
REQ-030 rst asserted mid-count SHALL abort any pending event; no wrap pulse SHALL follow reset.

Configuration
REQ-031 Macro COUNTER_SAT_EN SHALL compile in the sat_mode port and saturation logic.
REQ-032 With COUNTER_SAT_EN and sat_mode=1, an up count at limit and a down count at 0 SHALL hold d_out, pulse wrap, and set ovf_sticky.
REQ-033 Without COUNTER_SAT_EN, sat_mode SHALL be absent and behaviour SHALL be pure wrap as in REQ-021.

Structure
REQ-034 Shared package counter_pkg SHALL hold the WIDTH default, the all-ones limit reset constant, and an enum for count direction (CNT_DOWN=0, CNT_UP=1).
REQ-035 Sub-module counter_limit_reg SHALL own the limit register, its reset value, and the effective-limit mux of REQ-023.
REQ-036 No further hierarchy SHALL be used.

Verification (WIDTH=4)
REQ-037 Reset, en=1, up_down=1 for 17 cycles -> d_out 0..15 then 0; wrap high once on the cycle after 15->0; ovf_sticky=1.
REQ-038 limit_we with limit_in=9, d_out=12 -> d_out=9 next cycle; then count down from 9 to 0 -> next count gives d_out=9 and a wrap pulse.
REQ-039 clear and preset simultaneous with d_in=5 -> d_out=0; preset alone with d_in=14, limit=9 -> d_out=9.
REQ-040 With COUNTER_SAT_EN, sat_mode=1, limit=6, counting up from 4 -> 5, 6, 6, 6; wrap high on each hold cycle; ovf_clr together with a saturation event -> ovf_sticky stays 1.
REQ-041 limit_we with limit_in=0, en=1 -> d_out=0 and wrap=1 every cycle.
REQ-042 rst asserted between clk edges mid-count -> d_out=RESET_VAL and limit=15 immediately, with no clk edge required.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg -- shared definitions for the modulus binary counter.
//   CNT_WIDTH_DEFAULT : default counter/data width
//   LIMIT_RST_ONES    : all-ones source for the limit register reset value
//                       (sliced to WIDTH by the user)
//   cnt_dir_e         : count direction, matches the up_down pin encoding
package counter_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 4;

    localparam logic [31:0] LIMIT_RST_ONES = 32'hFFFF_FFFF;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

endpackage

// File: rtl/counter_limit_reg.sv
// counter_limit_reg -- holds the modulus limit (highest count value).
//   clk, rst      : clock, async active-high reset (limit -> all ones)
//   limit_we_i    : write strobe
//   limit_in_i    : new limit value
//   limit_o       : registered limit
//   limit_eff_o   : limit in force for the current edge; a write takes
//                   effect for bound checks on the same edge it lands
module counter_limit_reg
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             limit_we_i,
    input  logic [WIDTH-1:0] limit_in_i,
    output logic [WIDTH-1:0] limit_o,
    output logic [WIDTH-1:0] limit_eff_o
);

    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] limit_d;

    // The next-state value is exactly the effective limit for this edge.
    assign limit_d     = limit_we_i ? limit_in_i : limit_q;
    assign limit_o     = limit_q;
    assign limit_eff_o = limit_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_q <= LIMIT_RST_ONES[WIDTH-1:0];
        end else begin
            limit_q <= limit_d;
        end
    end

endmodule

// File: rtl/counter_binary_mod.sv
// counter_binary_mod -- up/down counter over 0..limit with programmable
// modulus, clear, clamped preset, wrap pulse and sticky overflow flag.
//   clk, rst     : clock, async active-high reset
//   en           : count enable (clear/preset/limit_we are not gated)
//   clear        : sync clear (highest priority)
//   preset/d_in  : sync load, clamped to the effective limit
//   up_down      : 1 = up, 0 = down
//   limit_we/limit_in : modulus limit write
//   sat_mode     : 1 = saturate at bounds (only with COUNTER_SAT_EN)
//   ovf_clr      : clears ovf_sticky (a same-edge set wins)
//   d_out        : count value
//   tc           : combinational terminal count
//   wrap         : one-cycle pulse after a wrap/saturation edge
//   ovf_sticky   : sticky record of wrap/saturation events
// Build option: define COUNTER_SAT_EN to add the sat_mode port and
// saturating behaviour; otherwise the counter always wraps.
module counter_binary_mod
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = CNT_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             preset,
    input  logic             up_down,
    input  logic [WIDTH-1:0] d_in,
    input  logic             limit_we,
    input  logic [WIDTH-1:0] limit_in,
`ifdef COUNTER_SAT_EN
    input  logic             sat_mode,
`endif
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] d_out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] limit_eff;
    logic             sat_on;
    cnt_dir_e         dir;

    counter_limit_reg #(
        .WIDTH (WIDTH)
    ) u_limit (
        .clk         (clk),
        .rst         (rst),
        .limit_we_i  (limit_we),
        .limit_in_i  (limit_in),
        .limit_o     (limit),
        .limit_eff_o (limit_eff)
    );

`ifdef COUNTER_SAT_EN
    assign sat_on = sat_mode;
`else
    assign sat_on = 1'b0;
`endif

    assign dir = cnt_dir_e'(up_down);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (preset) begin
            cnt_d = (d_in > limit_eff) ? limit_eff : d_in;
        end else begin
            if (en) begin
                if (dir == CNT_UP) begin
                    if (cnt_q == limit_eff) begin
                        wrap_d = 1'b1;
                        cnt_d  = sat_on ? cnt_q : '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        wrap_d = 1'b1;
                        cnt_d  = sat_on ? cnt_q : limit_eff;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            // Shrinking the limit below the count pulls the count down to
            // the new limit; that is a correction, not a wrap event.
            if (limit_we && (cnt_d > limit_in)) begin
                cnt_d  = limit_in;
                wrap_d = 1'b0;
            end
        end
    end

    // Set has priority over clear so a same-edge event is never lost.
    assign ovf_d = wrap_d | (ovf_q & ~ovf_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= RESET_VAL;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign d_out      = cnt_q;
    assign wrap       = wrap_q;
    assign ovf_sticky = ovf_q;
    assign tc         = ((dir == CNT_UP)   && (cnt_q == limit)) ||
                        ((dir == CNT_DOWN) && (cnt_q == '0));

endmodule
